vend_payout_ctrl: RTL and testbench
===================================

Name: vend_payout_ctrl

Overview:
Transaction controller for the candy vending machine, price 30 by default. It accepts coins through a valid/ready handshake and accumulates credit. When credit reaches the price it sequences the candy dispenser, then pays out change or a cancel refund one coin at a time. Change uses 25/10/5 denominations drawn from per-denomination coin inventory counters, which sit between the coin slot and the dispenser/hopper actuators.

Parameters:
PRICE, 30, candy price in credit units (multiple of 5, range 5..50)
CW, 6, credit width; must hold PRICE-5+25
INV_W, 4, width of each coin inventory counter
INV_INIT, 8, inventory value for every denomination at reset and on refill

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
coin_valid  in  1  coin present on coin
coin  in  2  00 cancel, 01 = 5, 10 = 10, 11 = 25
coin_ready  out  1  controller can accept a coin/cancel this cycle
credit  out  CW  current accumulated credit
busy  out  1  high in VEND or PAY
candy_req  out  1  request one candy from dispenser
candy_ack  in  1  dispenser done
coin_out_req  out  1  request hopper to eject one coin
coin_out_sel  out  2  denomination to eject, same encoding as coin (01/10/11)
coin_out_ack  in  1  hopper ejected the coin
refill  in  1  reload all inventories to INV_INIT
inv_5, inv_10, inv_25  out  INV_W each  coin inventory counts
err_nochange  out  1  one-cycle pulse: change/refund could not be completed

Behaviour:
- Reset values: state COLLECT, credit 0, remaining 0, coin_ready 1, busy 0, candy_req 0, coin_out_req 0, coin_out_sel 00, err_nochange 0, inventories INV_INIT.
- Reset at any cycle, including mid-VEND or mid-PAY, aborts the transaction. Outputs take their reset values at the next edge. No refund is owed.
- States: COLLECT, VEND, PAY. All outputs are registered.
- COLLECT: coin_ready=1. A coin is accepted on an edge where coin_valid & coin_ready.
  - For coin 01/10/11: credit <= credit+value. The matching inventory increments and saturates at 2^INV_W-1.
  - If the new credit >= PRICE on that same edge: remaining <= new credit-PRICE, candy_req <= 1, state <= VEND. candy_req is therefore visible 1 cycle after the coin.
- Cancel (00) with credit>0: remaining <= credit, credit <= 0, state <= PAY. No candy_req is issued.
- Cancel with credit=0: no effect.
- VEND: coin_ready=0; coin_valid is ignored and the coin is dropped.
  - candy_req holds high until candy_ack is sampled high, then drops at that edge.
  - On that edge credit <= 0. If remaining=0, state <= COLLECT; else state <= PAY.
- PAY, greedy selection evaluated each time no request is outstanding:
  - 25 if remaining>=25 and inv_25>0;
  - else 10 if remaining>=10 and inv_10>0;
  - else 5 if remaining>=5 and inv_5>0.
  - If a coin is selected: coin_out_req <= 1 and coin_out_sel <= denomination, held stable while req is high.
  - On the edge where coin_out_ack is sampled with req high: req <= 0, remaining -= value, that inventory decrements. When remaining reaches 0, state <= COLLECT.
  - No coin selectable while remaining>0: err_nochange pulses 1 cycle, remaining <= 0, state <= COLLECT. The residue is forfeited.
- Request cadence: at most one coin request per 2 cycles, i.e. req is low for at least 1 cycle between coins.
- candy_ack/coin_out_ack sampled while the matching req is low are ignored.
- refill is honored only in COLLECT with credit=0 and no coin accepted that cycle; an accepted coin wins. Otherwise refill is ignored.
- busy = (state != COLLECT). credit never exceeds PRICE+20.

Test Plan:
- 25 then 5 -> credit 25, then 30. candy_req 1 cycle after the 5. Ack -> state COLLECT, credit 0, no coin_out_req, inv_25=9, inv_5=9.
- 10, 10, 25 -> credit 45. After candy_ack, change 15: coin_out_sel 10 then 05 with one idle cycle between. inv_10=9 (10+... =8+2-1), inv_5=7, inv_25=9.
- 5, 10, cancel -> no candy_req. Refund coin_out_sel 10 then 5. credit 0 at cancel edge; busy high until the final ack.
- INV_INIT=0 instance: 25, 25 -> credit 50, candy, change 20. inv_10=inv_5=0 -> err_nochange pulses once, then COLLECT; inv_25 stays 2.
- coin_valid during VEND and stray coin_out_ack with req low -> credit and inventories unchanged, no state change.
- reset asserted while coin_out_req=1 in PAY -> next cycle all outputs at reset values, inventories INV_INIT. A subsequent coin_out_ack is ignored.

Source files
------------

// File: rtl/vend_payout_ctrl.sv
// vend_payout_ctrl: coin-accepting, candy-vending, change-paying controller.
//
// Coins are taken through a valid/ready handshake and accumulate as credit.
// When credit reaches PRICE the candy dispenser is requested. Change, or a
// cancel refund, is then paid one coin at a time using greedy 25/10/5
// selection drawn from per-denomination inventory counters.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   coin_valid, coin      coin slot handshake (00 cancel, 01=5, 10=10, 11=25)
//   coin_ready            slot accepts a coin/cancel this cycle
//   credit                accumulated credit
//   busy                  transaction in progress (VEND or PAY)
//   candy_req/candy_ack   dispenser request/completion
//   coin_out_req/_sel/_ack hopper request, denomination, completion
//   refill                reload all inventories to INV_INIT
//   inv_5, inv_10, inv_25 coin inventory counts
//   err_nochange          one-cycle pulse when change could not be completed
module vend_payout_ctrl #(
  parameter int PRICE    = 30,
  parameter int CW       = 6,
  parameter int INV_W    = 4,
  parameter int INV_INIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_valid,
  input  logic [1:0]       coin,
  output logic             coin_ready,
  output logic [CW-1:0]    credit,
  output logic             busy,
  output logic             candy_req,
  input  logic             candy_ack,
  output logic             coin_out_req,
  output logic [1:0]       coin_out_sel,
  input  logic             coin_out_ack,
  input  logic             refill,
  output logic [INV_W-1:0] inv_5,
  output logic [INV_W-1:0] inv_10,
  output logic [INV_W-1:0] inv_25,
  output logic             err_nochange
);

  typedef enum logic [1:0] {S_COLLECT, S_VEND, S_PAY} state_t;

  localparam logic [CW-1:0]    PRICE_C = CW'(PRICE);
  localparam logic [INV_W-1:0] INV_RST = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0] INV_MAX = '1;

  function automatic logic [CW-1:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   return CW'(5);
      2'b10:   return CW'(10);
      2'b11:   return CW'(25);
      default: return '0;
    endcase
  endfunction

  function automatic logic [INV_W-1:0] sat_inc(input logic [INV_W-1:0] v);
    return (v == INV_MAX) ? v : v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    credit_q, credit_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             candy_req_q, candy_req_d;
  logic             req_q, req_d;
  logic [1:0]       sel_q, sel_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [INV_W-1:0] inv5_q, inv5_d, inv10_q, inv10_d, inv25_q, inv25_d;

  logic             accept;
  logic [CW-1:0]    credit_sum;
  logic [CW-1:0]    sel_val;
  logic [1:0]       pick_sel;

  assign accept     = coin_valid & ready_q;
  assign credit_sum = credit_q + coin_value(coin);
  assign sel_val    = coin_value(sel_q);

  // Greedy change choice: largest denomination that fits and is in stock.
  always_comb begin
    pick_sel = 2'b00;
    if (rem_q >= CW'(25) && inv25_q != '0)      pick_sel = 2'b11;
    else if (rem_q >= CW'(10) && inv10_q != '0) pick_sel = 2'b10;
    else if (rem_q >= CW'(5) && inv5_q != '0)   pick_sel = 2'b01;
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    rem_d       = rem_q;
    candy_req_d = candy_req_q;
    req_d       = req_q;
    sel_d       = sel_q;
    err_d       = 1'b0;
    inv5_d      = inv5_q;
    inv10_d     = inv10_q;
    inv25_d     = inv25_q;

    case (state_q)
      S_COLLECT: begin
        if (accept && coin != 2'b00) begin
          credit_d = credit_sum;
          case (coin)
            2'b01:   inv5_d  = sat_inc(inv5_q);
            2'b10:   inv10_d = sat_inc(inv10_q);
            default: inv25_d = sat_inc(inv25_q);
          endcase
          if (credit_sum >= PRICE_C) begin
            rem_d       = credit_sum - PRICE_C;
            candy_req_d = 1'b1;
            state_d     = S_VEND;
          end
        end else if (accept && credit_q != '0) begin
          rem_d    = credit_q;
          credit_d = '0;
          state_d  = S_PAY;
        end else if (refill && credit_q == '0) begin
          // A cancel with zero credit is a no-op, so it does not block refill.
          inv5_d  = INV_RST;
          inv10_d = INV_RST;
          inv25_d = INV_RST;
        end
      end
      S_VEND: begin
        if (candy_ack) begin
          candy_req_d = 1'b0;
          credit_d    = '0;
          state_d     = (rem_q == '0) ? S_COLLECT : S_PAY;
        end
      end
      S_PAY: begin
        if (req_q) begin
          if (coin_out_ack) begin
            req_d = 1'b0;
            rem_d = rem_q - sel_val;
            case (sel_q)
              2'b01:   inv5_d  = inv5_q - 1'b1;
              2'b10:   inv10_d = inv10_q - 1'b1;
              default: inv25_d = inv25_q - 1'b1;
            endcase
            if (rem_q == sel_val) state_d = S_COLLECT;
          end
        end else if (rem_q == '0) begin
          state_d = S_COLLECT;
        end else if (pick_sel != 2'b00) begin
          // Selection only happens with req low, which enforces the idle
          // cycle between consecutive coins.
          req_d = 1'b1;
          sel_d = pick_sel;
        end else begin
          // Residue cannot be paid from stock; it is forfeited.
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase

    ready_d = (state_d == S_COLLECT);
    busy_d  = (state_d != S_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_COLLECT;
      credit_q    <= '0;
      rem_q       <= '0;
      candy_req_q <= 1'b0;
      req_q       <= 1'b0;
      sel_q       <= 2'b00;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      inv5_q      <= INV_RST;
      inv10_q     <= INV_RST;
      inv25_q     <= INV_RST;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      rem_q       <= rem_d;
      candy_req_q <= candy_req_d;
      req_q       <= req_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      inv5_q      <= inv5_d;
      inv10_q     <= inv10_d;
      inv25_q     <= inv25_d;
    end
  end

  assign coin_ready   = ready_q;
  assign credit       = credit_q;
  assign busy         = busy_q;
  assign candy_req    = candy_req_q;
  assign coin_out_req = req_q;
  assign coin_out_sel = sel_q;
  assign err_nochange = err_q;
  assign inv_5        = inv5_q;
  assign inv_10       = inv10_q;
  assign inv_25       = inv25_q;

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Testbench for vend_payout_ctrl: vector table, directed corner sequences,
// and randomized transactions checked against a transaction-level model.
module tb_vend_payout_ctrl;

  localparam int PRICE = 30;
  localparam int CW    = 6;
  localparam int INV_W = 4;
  localparam int INV_MAXV = 15;

  logic clk = 1'b0;
  logic reset;
  logic coin_valid, candy_ack, coin_out_ack, refill;
  logic [1:0] coin;
  logic coin_ready, busy, candy_req, coin_out_req, err_nochange;
  logic [CW-1:0] credit;
  logic [1:0] coin_out_sel;
  logic [INV_W-1:0] inv_5, inv_10, inv_25;

  // Second instance with empty inventories.
  logic z_cv, z_cack, z_oack, z_rf;
  logic [1:0] z_coin;
  logic z_ready, z_busy, z_creq, z_oreq, z_err;
  logic [CW-1:0] z_credit;
  logic [1:0] z_sel;
  logic [INV_W-1:0] z_inv5, z_inv10, z_inv25;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vend_payout_ctrl #(.PRICE(PRICE), .CW(CW), .INV_W(INV_W), .INV_INIT(8)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin(coin),
    .coin_ready(coin_ready), .credit(credit), .busy(busy),
    .candy_req(candy_req), .candy_ack(candy_ack),
    .coin_out_req(coin_out_req), .coin_out_sel(coin_out_sel),
    .coin_out_ack(coin_out_ack), .refill(refill),
    .inv_5(inv_5), .inv_10(inv_10), .inv_25(inv_25),
    .err_nochange(err_nochange));

  vend_payout_ctrl #(.PRICE(PRICE), .CW(CW), .INV_W(INV_W), .INV_INIT(0)) dut_z (
    .clk(clk), .reset(reset), .coin_valid(z_cv), .coin(z_coin),
    .coin_ready(z_ready), .credit(z_credit), .busy(z_busy),
    .candy_req(z_creq), .candy_ack(z_cack),
    .coin_out_req(z_oreq), .coin_out_sel(z_sel),
    .coin_out_ack(z_oack), .refill(z_rf),
    .inv_5(z_inv5), .inv_10(z_inv10), .inv_25(z_inv25),
    .err_nochange(z_err));

  typedef struct {
    logic rst; logic cv; logic [1:0] cn; logic cack; logic oack; logic rf;
    int credit; logic ready; logic bsy; logic creq; logic oreq; logic [1:0] sel;
    int i5; int i10; int i25; logic err;
  } vec_t;

  vec_t tbl[$];

  // Transaction-level model state: inventory per denomination (5,10,25).
  int m_inv[3];
  int m_credit;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic cv, logic [1:0] cn, logic ca,
                              logic oa, logic rf, int cr, logic rdy, logic bsy,
                              logic cq, logic oq, logic [1:0] sl, int i5,
                              int i10, int i25, logic er);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cn = cn; v.cack = ca; v.oack = oa; v.rf = rf;
    v.credit = cr; v.ready = rdy; v.bsy = bsy; v.creq = cq; v.oreq = oq;
    v.sel = sl; v.i5 = i5; v.i10 = i10; v.i25 = i25; v.err = er;
    return v;
  endfunction

  function automatic int dval(int d);
    return (d == 1) ? 5 : (d == 2) ? 10 : (d == 3) ? 25 : 0;
  endfunction

  task automatic clear_inputs();
    reset = 1'b0; coin_valid = 1'b0; coin = 2'b00; candy_ack = 1'b0;
    coin_out_ack = 1'b0; refill = 1'b0;
    z_cv = 1'b0; z_coin = 2'b00; z_cack = 1'b0; z_oack = 1'b0; z_rf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_inv = '{8, 8, 8};
    m_credit = 0;
  endtask

  task automatic chk_inv(input string tag);
    chk({tag, "_inv5"}, int'(inv_5), m_inv[0]);
    chk({tag, "_inv10"}, int'(inv_10), m_inv[1]);
    chk({tag, "_inv25"}, int'(inv_25), m_inv[2]);
  endtask

  // One random purchase or cancel, including payout, against the model.
  task automatic rand_txn(input int t);
    int rem, r, d, n, got;
    int tinv[3];
    int q[$];
    bit err_exp;
    string tg;
    tg = $sformatf("rt%0d", t);
    if ($urandom_range(0, 9) == 0) begin
      refill = 1'b1;
      tick();
      refill = 1'b0;
      m_inv = '{8, 8, 8};
      chk_inv({tg, "_refill"});
    end
    rem = -1;
    while (rem < 0) begin
      if ($urandom_range(0, 3) == 0) tick();
      if (m_credit > 0 && $urandom_range(0, 7) == 0) begin
        coin_valid = 1'b1; coin = 2'b00;
        tick();
        coin_valid = 1'b0;
        rem = m_credit;
        m_credit = 0;
        chk({tg, "_cancel_credit"}, int'(credit), 0);
        chk({tg, "_cancel_creq"}, int'(candy_req), 0);
        chk({tg, "_cancel_busy"}, int'(busy), 1);
      end else begin
        d = $urandom_range(1, 3);
        coin_valid = 1'b1; coin = 2'(d);
        tick();
        coin_valid = 1'b0;
        m_credit += dval(d);
        if (m_inv[d-1] < INV_MAXV) m_inv[d-1]++;
        chk({tg, "_credit"}, int'(credit), m_credit);
        if (m_credit >= PRICE) begin
          chk({tg, "_creq"}, int'(candy_req), 1);
          chk({tg, "_vend_busy"}, int'(busy), 1);
          n = $urandom_range(0, 3);
          for (int k = 0; k < n; k++) begin
            coin_valid = 1'($urandom_range(0, 1));
            coin = 2'($urandom_range(0, 3));
            tick();
            coin_valid = 1'b0;
            chk({tg, "_creq_hold"}, int'(candy_req), 1);
            chk({tg, "_vend_credit"}, int'(credit), m_credit);
          end
          candy_ack = 1'b1;
          tick();
          candy_ack = 1'b0;
          chk({tg, "_creq_drop"}, int'(candy_req), 0);
          chk({tg, "_credit_zero"}, int'(credit), 0);
          rem = m_credit - PRICE;
          m_credit = 0;
        end
      end
    end
    // Expected payout sequence from the greedy rule.
    tinv = m_inv;
    r = rem;
    err_exp = 1'b0;
    while (r > 0 && !err_exp) begin
      if (r >= 25 && tinv[2] > 0) begin q.push_back(3); r -= 25; tinv[2]--; end
      else if (r >= 10 && tinv[1] > 0) begin q.push_back(2); r -= 10; tinv[1]--; end
      else if (r >= 5 && tinv[0] > 0) begin q.push_back(1); r -= 5; tinv[0]--; end
      else err_exp = 1'b1;
    end
    foreach (q[k]) begin
      got = 0;
      for (int w = 0; w < 4 && got == 0; w++) begin
        if (coin_out_req === 1'b1) got = 1;
        else begin
          coin_out_ack = 1'($urandom_range(0, 1));
          tick();
          coin_out_ack = 1'b0;
        end
      end
      if (coin_out_req === 1'b1) got = 1;
      chk({tg, "_req_seen"}, got, 1);
      if (got == 0) begin
        do_reset();
        return;
      end
      chk({tg, "_sel"}, int'(coin_out_sel), q[k]);
      n = $urandom_range(0, 2);
      for (int k2 = 0; k2 < n; k2++) begin
        tick();
        chk({tg, "_req_hold"}, int'(coin_out_req), 1);
        chk({tg, "_sel_hold"}, int'(coin_out_sel), q[k]);
      end
      coin_out_ack = 1'b1;
      tick();
      coin_out_ack = 1'b0;
      chk({tg, "_req_gap"}, int'(coin_out_req), 0);
      m_inv[q[k]-1]--;
    end
    if (err_exp) begin
      got = 0;
      for (int w = 0; w < 4 && got == 0; w++) begin
        tick();
        if (err_nochange === 1'b1) got = 1;
      end
      chk({tg, "_err_seen"}, got, 1);
      chk({tg, "_err_busy"}, int'(busy), 0);
    end
    tick();
    chk({tg, "_no_extra_req"}, int'(coin_out_req), 0);
    chk({tg, "_err_low"}, int'(err_nochange), 0);
    chk({tg, "_idle_busy"}, int'(busy), 0);
    chk({tg, "_idle_ready"}, int'(coin_ready), 1);
    chk({tg, "_idle_credit"}, int'(credit), 0);
    chk_inv(tg);
  endtask

  initial begin
    int errs;
    bit oreq_seen;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // rst cv cn ca oa rf | credit rdy busy creq oreq sel i5 i10 i25 err
    tbl.push_back(mk(1,0,0,0,0,0,  0,1,0,0,0,0, 8, 8, 8,0));
    tbl.push_back(mk(0,0,0,0,0,0,  0,1,0,0,0,0, 8, 8, 8,0));
    tbl.push_back(mk(0,1,3,0,0,0, 25,1,0,0,0,0, 8, 8, 9,0));
    tbl.push_back(mk(0,1,1,0,0,0, 30,0,1,1,0,0, 9, 8, 9,0));
    tbl.push_back(mk(0,1,2,0,1,0, 30,0,1,1,0,0, 9, 8, 9,0));
    tbl.push_back(mk(0,0,0,1,0,0,  0,1,0,0,0,0, 9, 8, 9,0));
    tbl.push_back(mk(0,0,0,0,0,0,  0,1,0,0,0,0, 9, 8, 9,0));
    tbl.push_back(mk(1,0,0,0,0,0,  0,1,0,0,0,0, 8, 8, 8,0));
    tbl.push_back(mk(0,1,2,0,0,0, 10,1,0,0,0,0, 8, 9, 8,0));
    tbl.push_back(mk(0,1,2,0,0,0, 20,1,0,0,0,0, 8,10, 8,0));
    tbl.push_back(mk(0,1,3,0,0,0, 45,0,1,1,0,0, 8,10, 9,0));
    tbl.push_back(mk(0,1,1,0,0,0, 45,0,1,1,0,0, 8,10, 9,0));
    tbl.push_back(mk(0,0,0,1,0,0,  0,0,1,0,0,0, 8,10, 9,0));
    tbl.push_back(mk(0,0,0,0,1,0,  0,0,1,0,1,2, 8,10, 9,0));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,1,0,1,2, 8,10, 9,0));
    tbl.push_back(mk(0,0,0,0,1,0,  0,0,1,0,0,0, 8, 9, 9,0));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,1,0,1,1, 8, 9, 9,0));
    tbl.push_back(mk(0,0,0,0,1,0,  0,1,0,0,0,0, 7, 9, 9,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,1,0,0,0,0, 8, 8, 8,0));
    tbl.push_back(mk(0,1,1,0,0,0,  5,1,0,0,0,0, 9, 8, 8,0));
    tbl.push_back(mk(0,0,0,0,0,1,  5,1,0,0,0,0, 9, 8, 8,0));
    tbl.push_back(mk(0,1,2,0,0,1, 15,1,0,0,0,0, 9, 9, 8,0));
    tbl.push_back(mk(0,1,0,0,0,0,  0,0,1,0,0,0, 9, 9, 8,0));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,1,0,1,2, 9, 9, 8,0));
    tbl.push_back(mk(0,0,0,0,1,0,  0,0,1,0,0,0, 9, 8, 8,0));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,1,0,1,1, 9, 8, 8,0));
    tbl.push_back(mk(0,0,0,0,1,0,  0,1,0,0,0,0, 8, 8, 8,0));
    tbl.push_back(mk(0,1,0,0,0,0,  0,1,0,0,0,0, 8, 8, 8,0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; coin_valid = tbl[i].cv; coin = tbl[i].cn;
      candy_ack = tbl[i].cack; coin_out_ack = tbl[i].oack; refill = tbl[i].rf;
      tick();
      chk($sformatf("v%0d_credit", i), int'(credit), tbl[i].credit);
      chk($sformatf("v%0d_ready", i), int'(coin_ready), int'(tbl[i].ready));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].bsy));
      chk($sformatf("v%0d_creq", i), int'(candy_req), int'(tbl[i].creq));
      chk($sformatf("v%0d_oreq", i), int'(coin_out_req), int'(tbl[i].oreq));
      if (tbl[i].oreq)
        chk($sformatf("v%0d_sel", i), int'(coin_out_sel), int'(tbl[i].sel));
      chk($sformatf("v%0d_inv5", i), int'(inv_5), tbl[i].i5);
      chk($sformatf("v%0d_inv10", i), int'(inv_10), tbl[i].i10);
      chk($sformatf("v%0d_inv25", i), int'(inv_25), tbl[i].i25);
      chk($sformatf("v%0d_err", i), int'(err_nochange), int'(tbl[i].err));
    end
    clear_inputs();

    // Empty-inventory instance: change of 20 cannot be paid.
    do_reset();
    chk("z_rst_inv25", int'(z_inv25), 0);
    z_cv = 1'b1; z_coin = 2'b11;
    tick();
    chk("z_credit25", int'(z_credit), 25);
    chk("z_inv25_1", int'(z_inv25), 1);
    tick();
    z_cv = 1'b0;
    chk("z_credit50", int'(z_credit), 50);
    chk("z_creq", int'(z_creq), 1);
    z_cack = 1'b1;
    tick();
    z_cack = 1'b0;
    chk("z_pay_busy", int'(z_busy), 1);
    errs = 0;
    oreq_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (z_err === 1'b1) errs++;
      if (z_oreq === 1'b1) oreq_seen = 1'b1;
    end
    chk("z_err_pulses", errs, 1);
    chk("z_no_oreq", int'(oreq_seen), 0);
    chk("z_busy_end", int'(z_busy), 0);
    chk("z_ready_end", int'(z_ready), 1);
    chk("z_credit_end", int'(z_credit), 0);
    chk("z_inv25_end", int'(z_inv25), 2);
    chk("z_inv10_end", int'(z_inv10), 0);
    chk("z_inv5_end", int'(z_inv5), 0);

    // Reset while a change coin is being requested.
    do_reset();
    coin_valid = 1'b1; coin = 2'b11;
    tick();
    coin = 2'b10;
    tick();
    coin_valid = 1'b0;
    chk("e_credit35", int'(credit), 35);
    candy_ack = 1'b1;
    tick();
    candy_ack = 1'b0;
    tick();
    chk("e_oreq", int'(coin_out_req), 1);
    chk("e_sel5", int'(coin_out_sel), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("e_rst_oreq", int'(coin_out_req), 0);
    chk("e_rst_sel", int'(coin_out_sel), 0);
    chk("e_rst_busy", int'(busy), 0);
    chk("e_rst_ready", int'(coin_ready), 1);
    chk("e_rst_credit", int'(credit), 0);
    chk("e_rst_inv10", int'(inv_10), 8);
    chk("e_rst_inv25", int'(inv_25), 8);
    coin_out_ack = 1'b1;
    tick();
    coin_out_ack = 1'b0;
    tick();
    chk("e_late_ack_inv5", int'(inv_5), 8);
    chk("e_late_ack_oreq", int'(coin_out_req), 0);
    chk("e_late_ack_busy", int'(busy), 0);

    // Randomized transactions.
    do_reset();
    for (int t = 0; t < 300; t++) rand_txn(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
